// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-port arbiter.
package regfile_pkg;

    localparam int DEFAULT_DW     = 32;
    localparam int DEFAULT_AW     = 4;
    localparam int DEFAULT_PC_REG = 15;

    // Writeback source, used for the round-robin pointer and the grant.
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LD  = 1'b1
    } wb_src_t;

    // One writeback request at the default widths.
    typedef struct packed {
        logic [DEFAULT_AW-1:0] wa;
        logic [DEFAULT_DW-1:0] wd;
    } wb_req_t;

endpackage

// File: rtl/regfile_wr_arbiter_wb_slot.sv
// One-entry valid/ready holding slot for a writeback source, with an age flag
// that marks the slot as the younger one when the other slot was already
// holding a request at the moment this slot was filled.
module wb_slot
    import regfile_pkg::*;
#(
    parameter int DW = DEFAULT_DW,
    parameter int AW = DEFAULT_AW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_wa,
    input  logic [DW-1:0] in_wd,
    input  logic          granted,
    input  logic          other_full,
    input  logic          other_granted,
    output logic          full,
    output logic [AW-1:0] wa,
    output logic [DW-1:0] wd,
    output logic          young
);

    logic          full_q, full_d;
    logic          young_q, young_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [DW-1:0] wd_q, wd_d;
    logic          load;

    // Accept when empty or draining this cycle; track fill and relative age.
    always_comb begin
        in_ready = !full_q || granted;
        load     = in_valid && in_ready;
        full_d   = full_q;
        young_d  = young_q;
        wa_d     = wa_q;
        wd_d     = wd_q;
        if (load) begin
            full_d  = 1'b1;
            young_d = other_full && !other_granted;
            wa_d    = in_wa;
            wd_d    = in_wd;
        end else begin
            if (granted) begin
                full_d  = 1'b0;
                young_d = 1'b0;
            end else if (other_granted) begin
                young_d = 1'b0;
            end
        end
    end

    // Slot state register, emptied on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full_q  <= 1'b0;
            young_q <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
        end else begin
            full_q  <= full_d;
            young_q <= young_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
        end
    end

    assign full  = full_q;
    assign wa    = wa_q;
    assign wd    = wd_q;
    assign young = young_q;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter: ALU and load writebacks share the register file's single
// write port via holding slots and a round-robin grant; R15 goes to the PC.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int DW     = DEFAULT_DW,
    parameter int AW     = DEFAULT_AW,
    parameter int PC_REG = DEFAULT_PC_REG
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [AW-1:0]     alu_wa,
    input  logic [DW-1:0]     alu_wd,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [AW-1:0]     ld_wa,
    input  logic [DW-1:0]     ld_wd,
    output logic              we3,
    output logic [AW-1:0]     wa3,
    output logic [DW-1:0]     wd3,
    output logic              pc_we,
    output logic [DW-1:0]     pc_wd,
    output logic [2**AW-1:0]  pending
);

    logic          alu_full, alu_young, ld_full, ld_young;
    logic [AW-1:0] alu_s_wa, ld_s_wa, gnt_wa;
    logic [DW-1:0] alu_s_wd, ld_s_wd, gnt_wd;
    logic          gnt_alu, gnt_ld, gnt_pc;
    wb_src_t       rr_q, rr_d;

    logic          we3_q, we3_d, pc_we_q, pc_we_d;
    logic [AW-1:0] wa3_q, wa3_d;
    logic [DW-1:0] wd3_q, wd3_d, pc_wd_q, pc_wd_d;

    wb_slot #(.DW(DW), .AW(AW)) u_alu_slot (
        .clk(clk), .reset_n(reset_n),
        .in_valid(alu_valid), .in_ready(alu_ready),
        .in_wa(alu_wa), .in_wd(alu_wd),
        .granted(gnt_alu), .other_full(ld_full), .other_granted(gnt_ld),
        .full(alu_full), .wa(alu_s_wa), .wd(alu_s_wd), .young(alu_young)
    );

    wb_slot #(.DW(DW), .AW(AW)) u_ld_slot (
        .clk(clk), .reset_n(reset_n),
        .in_valid(ld_valid), .in_ready(ld_ready),
        .in_wa(ld_wa), .in_wd(ld_wd),
        .granted(gnt_ld), .other_full(alu_full), .other_granted(gnt_alu),
        .full(ld_full), .wa(ld_s_wa), .wd(ld_s_wd), .young(ld_young)
    );

    // Pick one slot: same destination favours the older (load on a tie), else round-robin.
    always_comb begin
        gnt_alu = 1'b0;
        gnt_ld  = 1'b0;
        if (alu_full && ld_full) begin
            if (alu_s_wa == ld_s_wa) begin
                if (ld_young && !alu_young) gnt_alu = 1'b1;
                else                        gnt_ld  = 1'b1;
            end else if (rr_q == SRC_ALU) begin
                gnt_alu = 1'b1;
            end else begin
                gnt_ld = 1'b1;
            end
        end else if (alu_full) begin
            gnt_alu = 1'b1;
        end else if (ld_full) begin
            gnt_ld = 1'b1;
        end
        gnt_wa = gnt_alu ? alu_s_wa : ld_s_wa;
        gnt_wd = gnt_alu ? alu_s_wd : ld_s_wd;
        gnt_pc = (gnt_alu || gnt_ld) && (gnt_wa == AW'(PC_REG));
        rr_d   = gnt_alu ? SRC_LD : (gnt_ld ? SRC_ALU : rr_q);
    end

    // Next values of the write-port and PC output registers; data holds when idle.
    always_comb begin
        we3_d   = (gnt_alu || gnt_ld) && !gnt_pc;
        pc_we_d = gnt_pc;
        wa3_d   = we3_d ? gnt_wa : wa3_q;
        wd3_d   = we3_d ? gnt_wd : wd3_q;
        pc_wd_d = gnt_pc ? gnt_wd : pc_wd_q;
    end

    // Output register and round-robin pointer; reset drops any in-flight write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we3_q   <= 1'b0;
            wa3_q   <= '0;
            wd3_q   <= '0;
            pc_we_q <= 1'b0;
            pc_wd_q <= '0;
            rr_q    <= SRC_ALU;
        end else begin
            we3_q   <= we3_d;
            wa3_q   <= wa3_d;
            wd3_q   <= wd3_d;
            pc_we_q <= pc_we_d;
            pc_wd_q <= pc_wd_d;
            rr_q    <= rr_d;
        end
    end

    // Registers with a write still queued in a slot or on the write port.
    always_comb begin
        pending = '0;
        if (alu_full) pending[alu_s_wa] = 1'b1;
        if (ld_full)  pending[ld_s_wa]  = 1'b1;
        if (we3_q)    pending[wa3_q]    = 1'b1;
    end

    assign we3   = we3_q;
    assign wa3   = wa3_q;
    assign wd3   = wd3_q;
    assign pc_we = pc_we_q;
    assign pc_wd = pc_wd_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed scoreboard bench for the register-file write-port arbiter.
module tb_regfile_wr_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        alu_valid, alu_ready, ld_valid, ld_ready;
    logic [3:0]  alu_wa, ld_wa, wa3;
    logic [31:0] alu_wd, ld_wd, wd3, pc_wd;
    logic        we3, pc_we;
    logic [15:0] pending;

    typedef struct {
        bit          is_pc;
        logic [3:0]  wa;
        logic [31:0] wd;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] shadow [16];
    int          checks = 0;
    int          errors = 0;
    int          ai, li;
    logic        a_fire, l_fire;

    regfile_wr_arbiter #(.DW(32), .AW(4), .PC_REG(15)) dut (
        .clk(clk), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_wa(alu_wa), .alu_wd(alu_wd),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_wa(ld_wa), .ld_wd(ld_wd),
        .we3(we3), .wa3(wa3), .wd3(wd3), .pc_we(pc_we), .pc_wd(pc_wd),
        .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic av, input logic [3:0] awa, input logic [31:0] awd,
                                 input logic lv, input logic [3:0] lwa, input logic [31:0] lwd);
        alu_valid = av;
        alu_wa    = awa;
        alu_wd    = awd;
        ld_valid  = lv;
        ld_wa     = lwa;
        ld_wd     = lwd;
    endtask

    task automatic expectWrite(input bit is_pc, input logic [3:0] wa, input logic [31:0] wd);
        exp_t e;
        e.is_pc = is_pc;
        e.wa    = wa;
        e.wd    = wd;
        exp_q.push_back(e);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Scoreboard: every write-port or PC pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (reset_n && (we3 || pc_we)) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_write", {30'd0, pc_we, we3}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("wr_kind", {31'd0, pc_we}, {31'd0, mon_e.is_pc});
                checkOutput("wr_we3", {31'd0, we3}, {31'd0, !mon_e.is_pc});
                if (mon_e.is_pc) begin
                    checkOutput("pc_wd", pc_wd, mon_e.wd);
                end else begin
                    checkOutput("wa3", {28'd0, wa3}, {28'd0, mon_e.wa});
                    checkOutput("wd3", wd3, mon_e.wd);
                end
            end
            if (we3) shadow[wa3] = wd3;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) shadow[i] = 32'd0;
        reset_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        checkOutput("rst_we3", {31'd0, we3}, 32'd0);
        checkOutput("rst_pc_we", {31'd0, pc_we}, 32'd0);
        checkOutput("rst_wa3", {28'd0, wa3}, 32'd0);
        checkOutput("rst_wd3", wd3, 32'd0);
        checkOutput("rst_pc_wd", pc_wd, 32'd0);
        checkOutput("rst_pending", {16'd0, pending}, 32'd0);
        checkOutput("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
        checkOutput("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
        reset_n = 1'b1;

        $display("[TB] single ALU write");
        @(negedge clk);
        applyStimulus(1, 4'd3, 32'hDEADBEEF, 0, 0, 0);
        expectWrite(0, 4'd3, 32'hDEADBEEF);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t1_pending_slot", {16'd0, pending}, 32'h0008);
        checkOutput("t1_we3_early", {31'd0, we3}, 32'd0);
        @(negedge clk);
        checkOutput("t1_we3", {31'd0, we3}, 32'd1);
        checkOutput("t1_pending_port", {16'd0, pending}, 32'h0008);
        @(negedge clk);
        checkOutput("t1_pending_clear", {16'd0, pending}, 32'd0);
        checkOutput("t1_we3_drop", {31'd0, we3}, 32'd0);

        $display("[TB] simultaneous, different registers");
        pulseReset();
        @(negedge clk);
        applyStimulus(1, 4'd1, 32'hA1, 1, 4'd2, 32'hB2);
        expectWrite(0, 4'd1, 32'hA1);
        expectWrite(0, 4'd2, 32'hB2);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t2_ld_ready_low", {31'd0, ld_ready}, 32'd0);
        checkOutput("t2_alu_ready", {31'd0, alu_ready}, 32'd1);
        checkOutput("t2_pending", {16'd0, pending}, 32'h0006);
        @(negedge clk);
        checkOutput("t2_ld_ready_back", {31'd0, ld_ready}, 32'd1);
        repeat (2) @(negedge clk);
        checkOutput("t2_idle", {31'd0, we3}, 32'd0);

        $display("[TB] same-register collision");
        @(negedge clk);
        applyStimulus(1, 4'd5, 32'h22, 1, 4'd5, 32'h11);
        expectWrite(0, 4'd5, 32'h11);
        expectWrite(0, 4'd5, 32'h22);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t3_pending", {16'd0, pending}, 32'h0020);
        repeat (3) @(negedge clk);
        checkOutput("t3_final_r5", shadow[5], 32'h22);

        $display("[TB] PC routing");
        @(negedge clk);
        applyStimulus(0, 0, 0, 1, 4'd15, 32'h100);
        expectWrite(1, 4'd15, 32'h100);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t4_pending_r15", {16'd0, pending}, 32'h8000);
        @(negedge clk);
        checkOutput("t4_pc_we", {31'd0, pc_we}, 32'd1);
        checkOutput("t4_we3_low", {31'd0, we3}, 32'd0);
        checkOutput("t4_pc_wd", pc_wd, 32'h100);
        checkOutput("t4_wa3_hold", {28'd0, wa3}, 32'd5);
        checkOutput("t4_wd3_hold", wd3, 32'h22);
        checkOutput("t4_pending_clear", {16'd0, pending}, 32'd0);
        @(negedge clk);
        checkOutput("t4_pc_we_drop", {31'd0, pc_we}, 32'd0);

        $display("[TB] streaming fairness");
        pulseReset();
        for (int i = 0; i < 5; i++) begin
            expectWrite(0, 4'(1 + i), 32'hA000 + i);
            expectWrite(0, 4'(8 + i), 32'hB000 + i);
        end
        ai = 0;
        li = 0;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            if (k >= 2 && k <= 11) checkOutput("t5_no_bubble", {31'd0, we3}, 32'd1);
            if (k == 12) checkOutput("t5_stream_end", {31'd0, we3}, 32'd0);
            applyStimulus(ai < 5, 4'(1 + ai), 32'hA000 + ai, li < 5, 4'(8 + li), 32'hB000 + li);
            a_fire = alu_valid && alu_ready;
            l_fire = ld_valid && ld_ready;
            @(posedge clk);
            if (a_fire) ai++;
            if (l_fire) li++;
        end
        checkOutput("t5_alu_sent", ai, 32'd5);
        checkOutput("t5_ld_sent", li, 32'd5);

        $display("[TB] reset mid-operation");
        @(negedge clk);
        applyStimulus(1, 4'd6, 32'h66, 1, 4'd7, 32'h77);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t6_pending_pre", {16'd0, pending}, 32'h00C0);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("t6_we3", {31'd0, we3}, 32'd0);
        checkOutput("t6_pc_we", {31'd0, pc_we}, 32'd0);
        checkOutput("t6_wa3", {28'd0, wa3}, 32'd0);
        checkOutput("t6_wd3", wd3, 32'd0);
        checkOutput("t6_pending", {16'd0, pending}, 32'd0);
        checkOutput("t6_alu_ready", {31'd0, alu_ready}, 32'd1);
        checkOutput("t6_ld_ready", {31'd0, ld_ready}, 32'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("t6_no_write", {30'd0, pc_we, we3}, 32'd0);
        end

        checkOutput("sb_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Write-port arbiter for the 15-entry register file. Two writeback sources, ALU results and memory loads, share the file's single write port (`we3`/`wa3`/`wd3`) through one-entry holding slots and a round-robin grant. Writes that target R15 go to the datapath's PC write interface instead. The block also exports a per-register pending mask for hazard detection.

## Interface
- `DW`, default 32: data width.
- `AW`, default 4: register address width.
- `PC_REG`, default 15: address routed to the PC interface, never to the file.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `reset_n`  in  1  one clock; reset is asynchronous and active-low.
- `alu_valid`  in  1  ALU writeback request.
- `alu_ready`  out  1  ALU slot can accept.
- `alu_wa`  in  AW  ALU destination register.
- `alu_wd`  in  DW  ALU result.
- `ld_valid`  in  1  load writeback request.
- `ld_ready`  out  1  load slot can accept.
- `ld_wa`  in  AW  load destination register.
- `ld_wd`  in  DW  load data.
- `we3`  out  1  register file write enable (registered).
- `wa3`  out  AW  register file write address (registered).
- `wd3`  out  DW  register file write data (registered).
- `pc_we`  out  1  PC write strobe (registered).
- `pc_wd`  out  DW  PC write data (registered).
- `pending`  out  2**AW  bit r is set while a write to r is held in a slot or in the output register.

## Operation
- **Slots.** Each source has a one-entry slot holding {valid, wa, wd, age}.
  - Transfer occurs when `x_valid && x_ready`.
  - `x_ready = !slot_full || slot_granted` (same-cycle drain and refill is allowed).
- **Grant.** At most one grant per cycle, evaluated combinationally from slot state.
  - One slot full: that slot is granted.
  - Both full, different `wa`: the round-robin pointer picks. After any grant the pointer moves to the other source.
  - Both full, same `wa`: the older slot wins, ignoring the pointer. The pointer is still updated.
  - Both full, same `wa`, loaded in the same cycle: the load wins (it is the older instruction). The ALU is granted next cycle and its value overwrites.
- **Age.** Each slot records whether it was loaded while the other slot was already full, which makes it the younger of the two.
- **Output register.** On a grant with `wa != PC_REG`: `we3=1`, `wa3=wa`, `wd3=wd`, `pc_we=0`.
  - With `wa == PC_REG`: `pc_we=1`, `pc_wd=wd`, `we3=0`, and `wa3`/`wd3` keep their previous values.
  - With no grant: `we3=0`, `pc_we=0`, and data outputs hold.
- **Pending.** `pending` = decode(full ALU slot) | decode(full load slot) | decode(`wa3`, if `we3`). R15 bits are included.
- **Reset.** Asynchronous assertion empties both slots, sets `we3`, `wa3`, `wd3`, `pc_we`, `pc_wd` and `pending` to 0, and sets the pointer to favor the ALU. Any writes in flight are discarded. Both `ready` outputs read 1 while `reset_n` is low.

## Timing
- Accept at edge E0 → grant evaluated in cycle E0..E1 → `we3`/`pc_we` high in cycle E1..E2 → register file captures at E2. Minimum latency is 2 edges.
- Sustained throughput is one write per cycle in total. With both sources streaming, each source gets one write every 2 cycles and each `ready` toggles.
- `ready` depends combinationally on slot state and on the grant only, never on `x_valid`, so there is no combinational loop.
- A held request must keep `x_wa`/`x_wd` stable only until the transfer; after that the slot owns the data.
- `pending` is combinational from registered state. It is valid in the same cycle as the slot fill and clears in the cycle after the `we3` pulse.

## Structure
- **Package `regfile_pkg`:**
  - `DW`, `AW` and `PC_REG` defaults.
  - `typedef enum logic {SRC_ALU, SRC_LD} wb_src_t` for the pointer and grant.
  - A `wb_req_t` struct {wa, wd}.
- **Sub-module `wb_slot`:** one-entry valid/ready holding register with age flag, instantiated twice. The top level contains the grant logic, the output register and the pending decode.

## Test plan
1. **Single ALU write.** `alu_valid`, `wa`=3, `wd`=0xDEADBEEF for one cycle → `we3`=1 two edges later with `wa3`=3 and `wd3`=0xDEADBEEF. `pending[3]` is high for 2 cycles.
2. **Simultaneous, different registers.** Both sources in the same cycle, ALU `wa`=1, load `wa`=2, after reset → ALU written first, load next cycle. `ld_ready`=0 for one cycle.
3. **Same-register collision, same cycle.** Both target `wa`=5, load 0x11 and ALU 0x22 → writes occur in the order load then ALU; the final R5 value is 0x22.
4. **PC routing.** Load `wa`=15, `wd`=0x100 → `pc_we`=1 with `pc_wd`=0x100, and `we3` stays 0.
5. **Streaming fairness.** Both sources hold valid for 10 cycles → grants alternate every cycle, with 5 writes per source and no bubbles.
6. **Reset mid-operation.** Drop `reset_n` while both slots are full → outputs are 0 immediately (asynchronously), no write occurs after release, and both `ready` read 1.
